// File: rtl/div_ctrl_if.sv
// ----------------------------------------------------------------------------
// div_ctrl_if
// Handshake/data bundle between the pipeline EX stage and the iterative
// divider.
//   master : pipeline side. Drives start, signed_div, annul, srcA, srcB and
//            observes stall, done, div_zero, hi, lo.
//   slave  : divider side (div_ctrl), with the opposite directions.
// ----------------------------------------------------------------------------
interface div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic             annul;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             stall;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, signed_div, annul, srcA, srcB,
        input  stall, done, div_zero, hi, lo
    );

    modport slave (
        input  start, signed_div, annul, srcA, srcB,
        output stall, done, div_zero, hi, lo
    );
endinterface

// File: rtl/div_ctrl.sv
// ----------------------------------------------------------------------------
// div_ctrl
// Multi-cycle restoring divider for DIV/DIVU, controlled by an IDLE/BUSY/DONE
// state machine.
//   clk    : sole clock, rising edge.
//   resetn : asynchronous active-low reset.
//   bus    : div_ctrl_if slave modport
//            start/signed_div/srcA/srcB : request, sampled in IDLE
//            annul                      : cancel request or in-flight divide
//            stall                      : combinational stall request
//            done                       : one-cycle result-valid pulse
//            div_zero/hi/lo             : flags, remainder, quotient of the
//                                         last completed divide
// A divide with a non-zero divisor takes 32 BUSY cycles, plus one DONE cycle.
// A zero divisor goes straight to DONE.
// ----------------------------------------------------------------------------
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     resetn,
    div_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       count_q, count_d;
    logic [WIDTH-1:0] quot_q, quot_d;       // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] rem_q, rem_d;         // partial remainder
    logic [WIDTH-1:0] divisor_q, divisor_d; // divisor magnitude
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_zero_q, div_zero_d;

    // Request-side decode
    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;

    // One restoring step
    logic [WIDTH:0]   rem_shift, rem_sub;
    logic             step_ge;
    logic [WIDTH-1:0] step_rem, step_quot;
    logic [WIDTH-1:0] q_final, r_final;
    logic             last_step;

    always_comb begin
        accept = (state_q == IDLE) && bus.start && !bus.annul;
        a_neg  = bus.signed_div && bus.srcA[WIDTH-1];
        b_neg  = bus.signed_div && bus.srcB[WIDTH-1];
        abs_a  = a_neg ? (-bus.srcA) : bus.srcA;
        abs_b  = b_neg ? (-bus.srcB) : bus.srcB;

        // Shift the next dividend bit into the remainder and try to subtract.
        // The partial remainder is always below the divisor, so WIDTH+1 bits
        // cover the shifted value.
        rem_shift = {rem_q, quot_q[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, divisor_q};
        step_ge   = (rem_shift >= {1'b0, divisor_q});
        step_rem  = step_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        step_quot = {quot_q[WIDTH-2:0], step_ge};

        // Sign fix-up of the final step. 0x80000000 / -1 wraps back to
        // 0x80000000 by two's-complement negation of the magnitude.
        q_final   = q_neg_q ? (-step_quot) : step_quot;
        r_final   = r_neg_q ? (-step_rem)  : step_rem;
        last_step = (count_q == 6'(WIDTH - 1));
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        if (bus.annul) begin
            // Cancel wins everywhere. Results are not touched.
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        quot_d    = abs_a;
                        rem_d     = '0;
                        divisor_d = abs_b;
                        q_neg_d   = a_neg ^ b_neg;
                        r_neg_d   = a_neg;
                        count_d   = '0;
                        if (bus.srcB == '0) begin
                            // A zero divisor completes immediately with
                            // the architected fixed result.
                            state_d    = DONE;
                            lo_d       = '1;
                            hi_d       = bus.srcA;
                            div_zero_d = 1'b1;
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    quot_d  = step_quot;
                    rem_d   = step_rem;
                    count_d = count_q + 6'd1;
                    if (last_step) begin
                        state_d    = DONE;
                        count_d    = '0;
                        lo_d       = q_final;
                        hi_d       = r_final;
                        div_zero_d = 1'b0;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            count_q    <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Stall is combinational so the pipeline holds in the request cycle
    // itself. It drops in DONE so the instruction advances with the result.
    assign bus.stall    = accept || (state_q == BUSY);
    assign bus.done     = (state_q == DONE);
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// ----------------------------------------------------------------------------
// tb_div_ctrl
// Directed test of div_ctrl. A vector table covers the arithmetic, and
// hand-written sequences cover annul, reset, re-start and back-to-back
// corners. Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_div_ctrl;
    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    div_ctrl_if #(.WIDTH(32)) bus ();

    div_ctrl #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue one request and follow it to completion.
    // lat counts cycles from the request cycle to done.
    // stall_cnt counts stalled cycles before done.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output int lat, output int stall_cnt);
        @(negedge clk);
        bus.srcA       = a;
        bus.srcB       = b;
        bus.signed_div = sgn;
        bus.start      = 1'b1;
        #1;
        stall_cnt = (bus.stall === 1'b1) ? 1 : 0;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.stall === 1'b1) stall_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int lat;
        int scnt;
        int pulses;

        checks = 0;
        errors = 0;

        vecs[0] = '{32'd100,      32'd7,          1'b0, 32'd14,       32'd2,        1'b0, 33};
        vecs[1] = '{32'hFFFFFFF9, 32'd2,          1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
        vecs[2] = '{32'h80000000, 32'hFFFFFFFF,   1'b1, 32'h80000000, 32'h0,        1'b0, 33};
        vecs[3] = '{32'h00001234, 32'h0,          1'b0, 32'hFFFFFFFF, 32'h00001234, 1'b1, 1};
        vecs[4] = '{32'hFFFFFFF9, 32'h0,          1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1};
        vecs[5] = '{32'hFFFFFFF9, 32'd2,          1'b0, 32'h7FFFFFFC, 32'h1,        1'b0, 33};
        vecs[6] = '{32'd7,        32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD, 32'h1,        1'b0, 33};
        vecs[7] = '{32'hFFFFFFF9, 32'hFFFFFFFE,   1'b1, 32'h3,        32'hFFFFFFFF, 1'b0, 33};
        vecs[8] = '{32'hFFFFFFFF, 32'h10,         1'b0, 32'h0FFFFFFF, 32'hF,        1'b0, 33};
        vecs[9] = '{32'd5,        32'd10,         1'b0, 32'h0,        32'd5,        1'b0, 33};

        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.annul      = 1'b0;
        bus.srcA       = '0;
        bus.srcB       = '0;
        resetn         = 1'b0;

        // Reset state
        idle_cycles(2);
        chk("reset_stall",    32'(bus.stall),    32'd0);
        chk("reset_done",     32'(bus.done),     32'd0);
        chk("reset_div_zero", 32'(bus.div_zero), 32'd0);
        chk("reset_hi",       bus.hi,            32'd0);
        chk("reset_lo",       bus.lo,            32'd0);
        resetn = 1'b1;
        idle_cycles(1);

        // Table-driven arithmetic and latency
        for (int i = 0; i < 10; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].sgn, lat, scnt);
            $display("vec %0d: a=%h b=%h s=%0b -> lo=%h hi=%h dz=%0b lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].sgn, bus.lo, bus.hi, bus.div_zero, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat),          32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_stalls", i),  32'(scnt),         32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_lo", i),      bus.lo,            vecs[i].exp_lo);
            chk($sformatf("vec%0d_hi", i),      bus.hi,            vecs[i].exp_hi);
            chk($sformatf("vec%0d_dz", i),      32'(bus.div_zero), 32'(vecs[i].exp_dz));
            chk($sformatf("vec%0d_done_stall", i), 32'(bus.stall), 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 32'(bus.done),  32'd0);
        end

        // Annul at T+10 of a BUSY divide: results from 100/7 must survive
        run_div(32'd100, 32'd7, 1'b0, lat, scnt);
        @(negedge clk);
        bus.srcA = 32'd1000; bus.srcB = 32'd3; bus.signed_div = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        idle_cycles(9);
        bus.annul = 1'b1;
        #1;
        chk("annul_busy_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        bus.annul = 1'b0;
        #1;
        chk("annul_idle_stall", 32'(bus.stall), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) pulses++;
            @(negedge clk);
        end
        $display("annul: lo=%h hi=%h done_pulses=%0d", bus.lo, bus.hi, pulses);
        chk("annul_no_done", 32'(pulses), 32'd0);
        chk("annul_keep_lo", bus.lo, 32'd14);
        chk("annul_keep_hi", bus.hi, 32'd2);

        // Annul together with start: request dropped, no stall
        bus.srcA = 32'd50; bus.srcB = 32'd5; bus.start = 1'b1; bus.annul = 1'b1;
        #1;
        chk("annul_start_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.start = 1'b0; bus.annul = 1'b0;
        #1;
        chk("annul_start_not_busy", 32'(bus.stall), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) pulses++;
            @(negedge clk);
        end
        $display("annul+start: lo=%h hi=%h done_pulses=%0d", bus.lo, bus.hi, pulses);
        chk("annul_start_no_done", 32'(pulses), 32'd0);
        chk("annul_start_keep_lo", bus.lo, 32'd14);

        // Asynchronous reset mid-BUSY, then a fresh divide
        bus.srcA = 32'd1000; bus.srcB = 32'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        idle_cycles(5);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(bus.stall),    32'd0);
        chk("rst_mid_done",  32'(bus.done),     32'd0);
        chk("rst_mid_dz",    32'(bus.div_zero), 32'd0);
        chk("rst_mid_hi",    bus.hi,            32'd0);
        chk("rst_mid_lo",    bus.lo,            32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_div(32'd9, 32'd3, 1'b0, lat, scnt);
        $display("post-reset 9/3: lo=%h hi=%h lat=%0d", bus.lo, bus.hi, lat);
        chk("rst_fresh_lat", 32'(lat), 32'd33);
        chk("rst_fresh_lo",  bus.lo,   32'd3);
        chk("rst_fresh_hi",  bus.hi,   32'd0);

        // start re-pulsed while BUSY is ignored
        @(negedge clk);
        bus.srcA = 32'd100; bus.srcB = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        idle_cycles(4);
        bus.srcA = 32'd50; bus.srcB = 32'd5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 6;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        $display("repulse: lo=%h hi=%h lat=%0d", bus.lo, bus.hi, lat);
        chk("repulse_lat", 32'(lat), 32'd33);
        chk("repulse_lo",  bus.lo,   32'd14);
        chk("repulse_hi",  bus.hi,   32'd2);
        @(negedge clk);
        chk("repulse_no_second", 32'(bus.stall), 32'd0);

        // start held across DONE -> IDLE is accepted again
        idle_cycles(2);
        bus.srcA = 32'd64; bus.srcB = 32'd8; bus.signed_div = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("held_first_lat",  32'(lat), 32'd33);
        chk("held_done_stall", 32'(bus.stall), 32'd0);
        chk("held_first_lo",   bus.lo, 32'd8);
        bus.srcA = 32'd65; bus.srcB = 32'd8;
        @(negedge clk);
        lat++;
        chk("held_reaccept_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        lat++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && lat < 150) begin
            @(negedge clk);
            lat++;
        end
        $display("held start: lo=%h hi=%h second_done_at=%0d", bus.lo, bus.hi, lat);
        chk("held_second_lat", 32'(lat), 32'd67);
        chk("held_second_lo",  bus.lo,   32'd8);
        chk("held_second_hi",  bus.hi,   32'd1);

        idle_cycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
